shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width, equal to log2(XLEN).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_funct3  input  3  3'b001 = SLL, 3'b101 = SRL/SRA; all others are unsupported.
REQ-008 SHALL have port req_arith  input  1  with funct3 3'b101, selects SRA (instruction bit 30).
REQ-009 SHALL have port req_data  input  XLEN  operand to shift.
REQ-010 SHALL have port req_shamt  input  SHW  shift amount, 0 to XLEN-1.
REQ-011 SHALL have port resp_valid  output  1  result present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-013 SHALL have port resp_data  output  XLEN  shifted result.
REQ-014 SHALL have port resp_err  output  1  unsupported funct3 flag, valid with resp_valid.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 SHALL drive req_ready high only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-018 SHALL, on acceptance, latch data, funct3, arith and shamt, and move to SHIFT if shamt is not 0 and funct3 is supported, otherwise to DONE.
REQ-019 SHALL, in SHIFT, shift the held value by exactly one bit per cycle and decrement a remaining-count register, moving to DONE in the cycle the count reaches 0.
REQ-020 SHALL fill vacated bits as follows: SLL inserts 0 at bit 0; SRL inserts 0 at the MSB; SRA replicates the latched MSB.
REQ-021 SHALL give a latency from accept edge to resp_valid high of shamt+1 cycles, and 1 cycle for shamt 0 or an unsupported funct3.
REQ-022 SHALL, for an unsupported funct3, return the data unchanged with resp_err = 1.
REQ-023 SHALL hold resp_valid, resp_data and resp_err stable in DONE until resp_ready is high, then return to IDLE on that edge.
REQ-024 SHALL NOT accept a new request in the cycle of the DONE-to-IDLE transition (req_ready is low), giving a minimum initiation interval of shamt+2 cycles.
REQ-025 SHALL ignore req_* inputs while busy; input changes during SHIFT do not affect the result.
REQ-026 SHALL allow resp_ready to be high before resp_valid; the result is then consumed on the first DONE edge.
REQ-027 SHALL, for shamt = XLEN-1, use exactly XLEN-1 SHIFT cycles with no count wrap-around.

Reset
REQ-028 SHALL, on reset assertion, immediately enter IDLE and clear all datapath registers, including during SHIFT or DONE, discarding the in-flight request with no response.
REQ-029 SHALL hold the following output values during reset: req_ready = 1, resp_valid = 0, resp_data = 0, resp_err = 0, busy = 0.

Configuration
REQ-030 SHALL, when macro SHIFT_SEQ_SRA_EN is defined, honour req_arith with funct3 3'b101 as SRA.
REQ-031 SHALL, when SHIFT_SEQ_SRA_EN is undefined, ignore req_arith and perform SRL for funct3 3'b101.

Structure
REQ-032 SHALL take funct3 codes, FSM state encodings and the default XLEN from the shared opcode package.
REQ-033 SHALL place the combinational one-bit step (direction and fill bit in, shifted value out) in sub-module shift_step, instantiated once.

Verification
REQ-034 SHALL verify: SLL with data 0x0000_0001 and shamt 4 gives resp_data 0x0000_0010, resp_valid 5 cycles after accept, resp_err 0.
REQ-035 SHALL verify: SRA (macro on) with 0x8000_0000 and shamt 31 gives 0xFFFF_FFFF; with macro off, the same request gives 0x0000_0001.
REQ-036 SHALL verify: shamt 0 with 0xDEAD_BEEF gives 0xDEAD_BEEF one cycle after accept.
REQ-037 SHALL verify: funct3 3'b000 with 0x1234_5678 gives 0x1234_5678 with resp_err 1 after 1 cycle.
REQ-038 SHALL verify: holding resp_ready low for 3 cycles in DONE keeps resp_data stable and req_ready low, with acceptance on the first edge with resp_ready high.
REQ-039 SHALL verify: asserting reset in the 3rd SHIFT cycle sets IDLE outputs immediately (asynchronous) and produces no response afterwards.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: default widths, the funct3
// codes it understands and the FSM state encoding.
package shift_sequencer_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned SHW_DEFAULT  = 5;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;  // SRL, or SRA when arith is set

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True for the funct3 codes that have a shift behind them.
  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRX);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shift step, purely combinational.
// Ports:
//   value    - operand
//   dir_left - 1 = shift toward MSB, 0 = shift toward LSB
//   fill     - bit entering the vacated position
//   result_c - shifted value
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] value,
  input  logic            dir_left,
  input  logic            fill,
  output logic [XLEN-1:0] result_c
);

  always_comb begin
    result_c = value;
    if (dir_left) begin
      result_c = {value[XLEN-2:0], fill};
    end else begin
      result_c = {fill, value[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Serial shifter: accepts one SLL/SRL/SRA request, shifts one bit per cycle,
// then holds the result until the consumer takes it.
// Build option: SHIFT_SEQ_SRA_EN enables SRA (req_arith with funct3 101);
// without it funct3 101 is always SRL.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   req_valid/req_ready         - request handshake
//   req_funct3, req_arith       - operation select
//   req_data, req_shamt         - operand and shift amount
//   resp_valid/resp_ready       - response handshake
//   resp_data, resp_err         - result, unsupported-funct3 flag
//   busy                        - high whenever not idle
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned SHW  = SHW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_arith,
  input  logic [XLEN-1:0] req_data,
  input  logic [SHW-1:0]  req_shamt,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic            busy
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] data_q, data_d, step_c;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            err_d;
  logic            dir_left_c, fill_c;

  assign dir_left_c = (funct3_q == F3_SLL);

`ifdef SHIFT_SEQ_SRA_EN
  logic arith_q, arith_d;
  // The held MSB never changes during SRA, so it is the latched sign bit.
  assign fill_c = ~dir_left_c & arith_q & data_q[XLEN-1];
`else
  logic unused_arith;
  assign unused_arith = req_arith;
  assign fill_c       = 1'b0;
`endif

  shift_step #(.XLEN(XLEN)) u_step (
    .value    (data_q),
    .dir_left (dir_left_c),
    .fill     (fill_c),
    .result_c (step_c)
  );

  assign resp_data = data_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    err_d    = resp_err;
`ifdef SHIFT_SEQ_SRA_EN
    arith_d  = arith_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          data_d   = req_data;
          funct3_d = req_funct3;
          cnt_d    = req_shamt;
          err_d    = ~f3_supported(req_funct3);
`ifdef SHIFT_SEQ_SRA_EN
          arith_d  = req_arith;
`endif
          if (f3_supported(req_funct3) && (req_shamt != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_c;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      funct3_q   <= '0;
`ifdef SHIFT_SEQ_SRA_EN
      arith_q    <= 1'b0;
`endif
      resp_err   <= 1'b0;
      resp_valid <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
`ifdef SHIFT_SEQ_SRA_EN
      arith_q    <= arith_d;
`endif
      resp_err   <= err_d;
      resp_valid <= (state_d == ST_DONE);
      req_ready  <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule
